// File: rtl/seq_shift_unit.sv
// Multi-cycle shifter for the execute stage: SLL/SRL/SRA/ROTL by a variable amount,
// up to STEP bits per clock, behind a start/busy/done handshake with kill abort.
module seq_shift_unit #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH),
    parameter int STEP    = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               kill,
    input  logic [1:0]         mode,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic [WIDTH-1:0]   din,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   dout
);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    typedef enum logic [1:0] {
        M_SLL  = 2'b00,
        M_SRL  = 2'b01,
        M_SRA  = 2'b10,
        M_ROTL = 2'b11
    } mode_t;

    localparam logic [SHAMT_W-1:0] STEP_V = SHAMT_W'(STEP);

    state_t             state_q;
    mode_t              mode_q;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [SHAMT_W-1:0] rem_q, rem_d;
    logic [WIDTH-1:0]   dout_q;
    logic               done_q;
    logic [SHAMT_W-1:0] step_amt;

    // One partial step; step_amt is never 0 when the result is consumed.
    always_comb begin
        step_amt = (rem_q < STEP_V) ? rem_q : STEP_V;
        acc_d    = acc_q;
        rem_d    = rem_q - step_amt;
        case (mode_q)
            M_SLL:  acc_d = acc_q << step_amt;
            M_SRL:  acc_d = acc_q >> step_amt;
            M_SRA:  acc_d = $signed(acc_q) >>> step_amt;
            M_ROTL: acc_d = (acc_q << step_amt) | (acc_q >> (WIDTH - int'(step_amt)));
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            mode_q  <= M_SLL;
            acc_q   <= '0;
            rem_q   <= '0;
            dout_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start && !kill) begin
                        acc_q   <= din;
                        rem_q   <= shamt;
                        mode_q  <= mode_t'(mode);
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (kill) begin
                        state_q <= IDLE;
                    end else if (rem_q == '0) begin
                        dout_q  <= acc_q;
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        acc_q <= acc_d;
                        rem_q <= rem_d;
                    end
                end
            endcase
        end
    end

    assign busy = (state_q == SHIFT);
    assign done = done_q;
    assign dout = dout_q;

endmodule

// File: doc/seq_shift_unit.md
# seq_shift_unit

Multi-cycle, parametrised shift unit for the MIPS execute stage, generalising the fixed shift-left-by-2 offset shifter into a variable-amount logical/arithmetic/rotate shifter. It accepts an operand, shift amount and mode through a start/busy/done handshake and shifts by up to `STEP` bits per clock, trading latency for area. A pipeline `kill` input lets hazard/flush logic abort an in-flight operation.

## Interface
- `WIDTH`, default 32: operand and result width in bits.
- `SHAMT_W`, default `$clog2(WIDTH)` (5): shift-amount width.
- `STEP`, default 1: maximum bits shifted per cycle. Legal range is 1 to WIDTH-1.

- `clk` input 1: single clock. All state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `start` input 1: request. Accepted only while idle.
- `kill` input 1: synchronous abort, for pipeline flush.
- `mode` input 2: 00 = SLL, 01 = SRL, 10 = SRA, 11 = ROTL.
- `shamt` input SHAMT_W: shift amount, 0 to WIDTH-1.
- `din` input WIDTH: operand.
- `busy` output 1: operation in flight.
- `done` output 1: one-cycle pulse when `dout` is updated.
- `dout` output WIDTH: result register. Holds its value until the next completion.

## Operation
- Internal registers: state, `acc` (WIDTH), `rem` (SHAMT_W), latched `mode_q`.
- There are two states, IDLE and SHIFT.
- IDLE:
  - When `start=1` and `kill=0`, the operation is accepted.
  - On acceptance: `acc<=din`, `rem<=shamt`, `mode_q<=mode`, and the state goes to SHIFT.
  - `start` while in SHIFT is ignored. It is not queued.
- SHIFT, each edge:
  - If `kill=1`: go to IDLE. No `done`, `dout` unchanged.
  - Else if `rem==0`: `dout<=acc`, `done<=1`, go to IDLE.
  - Else: compute `s=min(STEP,rem)`, shift `acc` by `s` according to `mode_q`, and set `rem<=rem-s`.
- Shift rules for each partial step:
  - SLL: zero fill from the LSB side.
  - SRL: zero fill from the MSB side.
  - SRA: fill with `acc[WIDTH-1]`, re-sampled every step. The result equals a single arithmetic shift by `shamt`.
  - ROTL: bits leaving the MSB re-enter at the LSB.
- The final result must equal a single-cycle shift of `din` by `shamt` in the same mode, for every `STEP`.
- `shamt=0` passes through SHIFT once and completes with `dout=din`.
- `busy` is high exactly when state is SHIFT.
- `done` is registered and high for exactly one cycle. In the `done` cycle the state is IDLE, so `busy=0`.
- Back-to-back operation: a `start` in the same cycle that `done` is high is accepted.
- `kill` in IDLE blocks acceptance, even if `start=1`.

## Timing
- Reset values, applied asynchronously while `rst=1`:
  - state = IDLE
  - `busy=0`, `done=0`
  - `dout=0`, `acc=0`, `rem=0`, `mode_q=00`
- Reset release: the first accepting edge can be the first rising edge after `rst` falls.
- Latency: with acceptance at edge k, `done` rises after edge k+1+ceil(shamt/STEP).
  - `busy` is high from edge k to that edge.
  - Throughput is one operation per 1+ceil(shamt/STEP)+... cycles. A new start can be accepted in the `done` cycle.
- Worked cases:
  - STEP=1, shamt=31: done at k+32.
  - STEP=4, shamt=31: done at k+9.
  - Any STEP, shamt=0: done at k+1.
- Inputs `din`, `shamt` and `mode` are sampled only at the accepting edge. Later changes have no effect.
- `rst` during SHIFT aborts immediately. No `done` is produced and `dout` returns to 0.
- `kill` and `rem==0` on the same edge: `kill` wins, so no `done` and `dout` is held.

## Test plan
- **Reset:** assert `rst` mid-sim with `dout` non-zero. Required: `dout=0`, `busy=0`, `done=0` immediately, without waiting for a clock edge.
- **SLL, STEP=1:** `din=0x00000003`, `shamt=2`, `mode=00`. Required: `done` after edge k+3, `dout=0x0000000C`. Then `din=0x55555555`, `shamt=1`. Required: `0xAAAAAAAA`.
- **SRA vs SRL, STEP=4:** `din=0x80000000`, `shamt=4`. Required: SRA gives `dout=0xF8000000` and SRL gives `0x08000000`, each with `done` at k+2. With `shamt=31`, SRA gives `0xFFFFFFFF` at k+9.
- **ROTL:** `din=0x80000001`, `shamt=1`. Required: `dout=0x00000003`. With `shamt=0`, required: `dout=din` and `done` at k+1.
- **Handshake:**
  - A `start` pulsed while `busy` is ignored; `dout` reflects only the first operation.
  - A `start` in the `done` cycle is accepted.
  - `busy` and `done` are never high together.
- **Abort:** `kill` two cycles into a `shamt=10` STEP=1 operation. Required: `busy` drops, no `done`, and `dout` keeps its previous value. Separately, `rst` mid-shift gives `dout=0` and no `done`.
